// File: rtl/ser_pkg.sv
// Shared serializer definitions: memcpy engine states and sizing constants.
package ser_pkg;

  // Bytes in an indirect (string) payload pointer, little-endian.
  localparam int unsigned PTR_BYTES = 8;
  // Widest DRAM port any serializer engine is built for.
  localparam int unsigned MAX_LANES = 16;

  typedef enum logic [2:0] {
    StIdle,
    StPtrRd,
    StPtrWait,
    StRd,
    StRdWait,
    StWr,
    StWrWait,
    StDone
  } ser_memcpy_state_t;

endpackage

// File: rtl/ser_lane_collect.sv
// Per-burst completion tracker: sticky per-lane valid mask plus read-data capture.
// all_done fires in the cycle the last enabled lane completes; the mask clears on that edge.
module ser_lane_collect
  import ser_pkg::*;
#(
  parameter int unsigned LANES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LANES-1:0]   lane_en,
  input  logic [LANES-1:0]   valid,
  input  logic [LANES*8-1:0] data_in,
  output logic               all_done,
  output logic [LANES*8-1:0] data
);

  logic [LANES-1:0]   mask_q, mask_d, hit;
  logic [LANES*8-1:0] data_q, data_d;

  // Merge this cycle's completions; data output already includes bytes arriving now.
  always_comb begin
    hit      = valid & lane_en;
    mask_d   = mask_q | hit;
    all_done = (lane_en != '0) && ((mask_d & lane_en) == lane_en);
    data_d   = data_q;
    for (int i = 0; i < LANES; i++) begin
      if (hit[i]) begin
        data_d[i*8 +: 8] = data_in[i*8 +: 8];
      end
    end
    data = data_d;
    if (all_done) begin
      mask_d = '0;
    end
  end

  // Mask and capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      data_q <= '0;
    end else begin
      mask_q <= mask_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/ser_memcpy_multi.sv
// Multi-lane DRAM copy engine: copies len bytes (directly or via an 8-byte LE pointer)
// into a downward-growing buffer ending at write_point, in bursts of up to LANES bytes.
module ser_memcpy_multi
  import ser_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LEN_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    indirect,
  input  logic [ADDR_W-1:0]       src_addr,
  input  logic [LEN_W-1:0]        len,
  input  logic [ADDR_W-1:0]       write_point,
  output logic                    ready,
  output logic                    done,
  output logic [ADDR_W-1:0]       new_write_point,
  output logic [LANES-1:0]        dram_en,
  output logic                    dram_rdwr,
  output logic [LANES*ADDR_W-1:0] dram_addr,
  output logic [LANES*8-1:0]      dram_data_out,
  input  logic [LANES*8-1:0]      dram_data_in,
  input  logic [LANES-1:0]        dram_valid
);

  localparam int unsigned PtrLanes = (LANES < PTR_BYTES) ? LANES : PTR_BYTES;
  localparam int unsigned PtrW     = PTR_BYTES * 8;

  ser_memcpy_state_t state_q, state_d;

  logic [ADDR_W-1:0]       src_q, src_d, dst_q, dst_d, nwp_q, nwp_d;
  logic [LEN_W-1:0]        len_q, len_d, off_q, off_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic [3:0]              ptr_cnt_q, ptr_cnt_d;
  logic [LANES-1:0]        dram_en_q, dram_en_d;
  logic                    dram_rdwr_q, dram_rdwr_d;
  logic [LANES*ADDR_W-1:0] dram_addr_q, dram_addr_d;
  logic [LANES*8-1:0]      dram_data_q, dram_data_d;

  logic [LEN_W-1:0]   remaining, chunk;
  logic [3:0]         ptr_left, ptr_chunk;
  logic [LANES-1:0]   data_mask, ptr_mask;
  logic [5:0]         bsel;
  logic               lanes_done;
  logic [LANES*8-1:0] lane_data;

  ser_lane_collect #(
    .LANES(LANES)
  ) u_collect (
    .clk     (clk),
    .reset   (reset),
    .lane_en (dram_en_q),
    .valid   (dram_valid),
    .data_in (dram_data_in),
    .all_done(lanes_done),
    .data    (lane_data)
  );

  // Burst sizing for payload and pointer beats.
  always_comb begin
    remaining = len_q - off_q;
    chunk     = (remaining < LEN_W'(LANES)) ? remaining : LEN_W'(LANES);
    ptr_left  = 4'(PTR_BYTES) - ptr_cnt_q;
    ptr_chunk = (ptr_left < 4'(PtrLanes)) ? ptr_left : 4'(PtrLanes);
    for (int i = 0; i < LANES; i++) begin
      data_mask[i] = (LEN_W'(i) < chunk);
      ptr_mask[i]  = (4'(i) < ptr_chunk);
    end
  end

  // Next-state and DRAM request generation.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    nwp_d       = nwp_q;
    len_d       = len_q;
    off_d       = off_q;
    ptr_d       = ptr_q;
    ptr_cnt_d   = ptr_cnt_q;
    dram_en_d   = dram_en_q;
    dram_rdwr_d = dram_rdwr_q;
    dram_addr_d = dram_addr_q;
    dram_data_d = dram_data_q;
    bsel        = '0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          src_d     = src_addr;
          dst_d     = write_point - ADDR_W'(len) + ADDR_W'(1);
          nwp_d     = write_point - ADDR_W'(len);
          len_d     = len;
          off_d     = '0;
          ptr_cnt_d = '0;
          if (len == '0) begin
            state_d = StDone;
          end else if (indirect) begin
            state_d = StPtrRd;
          end else begin
            state_d = StRd;
          end
        end
      end
      StPtrRd: begin
        dram_en_d   = ptr_mask;
        dram_rdwr_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
          dram_addr_d[i*ADDR_W +: ADDR_W] = src_q + ADDR_W'(ptr_cnt_q) + ADDR_W'(i);
        end
        state_d = StPtrWait;
      end
      StPtrWait: begin
        if (lanes_done) begin
          dram_en_d = '0;
          for (int i = 0; i < PtrLanes; i++) begin
            if (ptr_mask[i]) begin
              bsel = 6'((int'(ptr_cnt_q) + i) * 8);
              ptr_d[bsel +: 8] = lane_data[i*8 +: 8];
            end
          end
          ptr_cnt_d = ptr_cnt_q + ptr_chunk;
          if (ptr_cnt_d == 4'(PTR_BYTES)) begin
            src_d   = ADDR_W'(ptr_d);
            state_d = StRd;
          end else begin
            state_d = StPtrRd;
          end
        end
      end
      StRd: begin
        dram_en_d   = data_mask;
        dram_rdwr_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
          dram_addr_d[i*ADDR_W +: ADDR_W] = src_q + ADDR_W'(off_q) + ADDR_W'(i);
        end
        state_d = StRdWait;
      end
      StRdWait: begin
        if (lanes_done) begin
          dram_en_d = '0;
          state_d   = StWr;
        end
      end
      StWr: begin
        dram_en_d   = data_mask;
        dram_rdwr_d = 1'b1;
        for (int i = 0; i < LANES; i++) begin
          dram_addr_d[i*ADDR_W +: ADDR_W] = dst_q + ADDR_W'(off_q) + ADDR_W'(i);
        end
        dram_data_d = lane_data;
        state_d     = StWrWait;
      end
      StWrWait: begin
        if (lanes_done) begin
          dram_en_d = '0;
          off_d     = off_q + chunk;
          state_d   = (off_d == len_q) ? StDone : StRd;
        end
      end
      StDone: begin
        if (!en) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any transfer immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      nwp_q       <= '0;
      len_q       <= '0;
      off_q       <= '0;
      ptr_q       <= '0;
      ptr_cnt_q   <= '0;
      dram_en_q   <= '0;
      dram_rdwr_q <= 1'b0;
      dram_addr_q <= '0;
      dram_data_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      nwp_q       <= nwp_d;
      len_q       <= len_d;
      off_q       <= off_d;
      ptr_q       <= ptr_d;
      ptr_cnt_q   <= ptr_cnt_d;
      dram_en_q   <= dram_en_d;
      dram_rdwr_q <= dram_rdwr_d;
      dram_addr_q <= dram_addr_d;
      dram_data_q <= dram_data_d;
    end
  end

  assign ready           = (state_q == StIdle);
  assign done            = (state_q == StDone);
  assign new_write_point = nwp_q;
  assign dram_en         = dram_en_q;
  assign dram_rdwr       = dram_rdwr_q;
  assign dram_addr       = dram_addr_q;
  assign dram_data_out   = dram_data_q;

endmodule

// File: tb/tb_ser_memcpy_multi.sv
// Bench: three engines (8, 4, 16 lanes) run identical transfers against private DRAM models;
// results are compared with a byte-array reference of the copy.
module tb_ser_memcpy_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        indirect = 1'b0;
  logic [63:0] src_addr = '0;
  logic [63:0] write_point = '0;
  logic [31:0] len = '0;

  logic [2:0]  ready_v, done_v, d_rdwr;
  logic [63:0] nwp_v [3];
  logic [15:0] d_en [3];
  logic [15:0] d_valid [3];
  logic [63:0] d_addr [3][16];
  logic [7:0]  d_wdata [3][16];
  logic [7:0]  d_rdata [3][16];

  logic [7:0]  mem [3][1024];
  logic [7:0]  img [1024];
  logic [7:0]  exp_mem [1024];
  logic        fill_en = 1'b0;
  logic        skew = 1'b0;

  logic [15:0] prev_en [3];
  logic [15:0] served [3];
  logic [2:0]  cnt [3][16];
  int          rd_beats [3], wr_beats [3], wr_bytes [3], viol [3];
  logic [15:0] first_pat [3], last_pat [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 8 : ((g == 1) ? 4 : 16);
    logic [L-1:0]    en_o, valid_i;
    logic [L*64-1:0] addr_o;
    logic [L*8-1:0]  wd_o, rd_i;

    ser_memcpy_multi #(
      .LANES (L),
      .ADDR_W(64),
      .LEN_W (32)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .en             (en),
      .indirect       (indirect),
      .src_addr       (src_addr),
      .len            (len),
      .write_point    (write_point),
      .ready          (ready_v[g]),
      .done           (done_v[g]),
      .new_write_point(nwp_v[g]),
      .dram_en        (en_o),
      .dram_rdwr      (d_rdwr[g]),
      .dram_addr      (addr_o),
      .dram_data_out  (wd_o),
      .dram_data_in   (rd_i),
      .dram_valid     (valid_i)
    );

    assign d_en[g]  = 16'(en_o);
    assign valid_i  = d_valid[g][L-1:0];

    for (genvar i = 0; i < 16; i++) begin : g_lane
      if (i < L) begin : g_on
        assign d_addr[g][i]   = addr_o[i*64 +: 64];
        assign d_wdata[g][i]  = wd_o[i*8 +: 8];
        assign rd_i[i*8 +: 8] = d_rdata[g][i];
      end else begin : g_off
        assign d_addr[g][i]  = '0;
        assign d_wdata[g][i] = '0;
      end
    end
  end

  // DRAM model: each enabled lane completes once per request after 1 cycle (or 1..4 when skewed);
  // when skewed, idle lanes of an active burst also get spurious valid pulses.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      prev_en[g] <= d_en[g];
      if (fill_en) begin
        for (int a = 0; a < 1024; a++) mem[g][a] <= img[a];
        rd_beats[g]  <= 0;
        wr_beats[g]  <= 0;
        wr_bytes[g]  <= 0;
        viol[g]      <= 0;
        first_pat[g] <= '0;
        last_pat[g]  <= '0;
      end else if (prev_en[g] == '0 && d_en[g] != '0) begin
        if (d_rdwr[g]) begin
          if (wr_beats[g] == 0) first_pat[g] <= d_en[g];
          last_pat[g] <= d_en[g];
          wr_beats[g] <= wr_beats[g] + 1;
          wr_bytes[g] <= wr_bytes[g] + $countones(d_en[g]);
        end else begin
          rd_beats[g] <= rd_beats[g] + 1;
        end
      end
      for (int i = 0; i < 16; i++) begin
        if (!d_en[g][i]) begin
          if (prev_en[g][i] && !served[g][i]) viol[g] <= viol[g] + 1;
          served[g][i]  <= 1'b0;
          cnt[g][i]     <= '0;
          d_valid[g][i] <= skew && (d_en[g] != '0) && ($urandom_range(0, 3) == 0);
          d_rdata[g][i] <= 8'($urandom);
        end else if (served[g][i]) begin
          d_valid[g][i] <= 1'b0;
        end else if (cnt[g][i] == 0) begin
          cnt[g][i]     <= skew ? 3'($urandom_range(1, 4)) : 3'd1;
          d_valid[g][i] <= 1'b0;
        end else if (cnt[g][i] == 1) begin
          d_valid[g][i] <= 1'b1;
          served[g][i]  <= 1'b1;
          cnt[g][i]     <= '0;
          if (d_rdwr[g]) mem[g][d_addr[g][i][9:0]] <= d_wdata[g][i];
          else d_rdata[g][i] <= mem[g][d_addr[g][i][9:0]];
        end else begin
          cnt[g][i]     <= cnt[g][i] - 3'd1;
          d_valid[g][i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lanes_of(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 4 : 16);
  endfunction

  function automatic logic [15:0] lane_mask(input int n);
    logic [16:0] m;
    m = (17'd1 << n) - 17'd1;
    return m[15:0];
  endfunction

  task automatic rand_img();
    for (int a = 0; a < 1024; a++) img[a] = 8'($urandom);
  endtask

  task automatic fill();
    @(negedge clk) fill_en = 1'b1;
    @(negedge clk) fill_en = 1'b0;
  endtask

  task automatic run_xfer(input bit ind, input logic [63:0] src, input int n,
                          input logic [63:0] wp, input bit sk);
    int          cyc, bad, lw, beats, pl, pbeats;
    logic [63:0] ptr, base;
    skew = sk;
    fill();
    en          = 1'b1;
    indirect    = ind;
    src_addr    = src;
    len         = 32'(n);
    write_point = wp;
    @(negedge clk);
    // Inputs after the start cycle must not matter.
    src_addr    = {$urandom, $urandom};
    len         = $urandom;
    write_point = {$urandom, $urandom};
    indirect    = 1'($urandom);
    cyc = 1;
    while (done_v != 3'b111 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", 64'(done_v), 64'h7);
    if (n == 0) chk("zero_len_latency", 64'(cyc), 64'd1);
    for (int g = 0; g < 3; g++) chk($sformatf("nwp[%0d]", g), nwp_v[g], wp - 64'(n));
    en = 1'b0;
    @(negedge clk);
    chk("ready_after_done", 64'(ready_v), 64'h7);
    chk("done_cleared", 64'(done_v), 64'h0);

    for (int a = 0; a < 1024; a++) exp_mem[a] = img[a];
    ptr = src;
    if (ind) for (int k = 0; k < 8; k++) ptr[k*8 +: 8] = img[10'(src + 64'(k))];
    base = wp - 64'(n) + 64'd1;
    for (int i = 0; i < n; i++) exp_mem[10'(base + 64'(i))] = img[10'(ptr + 64'(i))];

    for (int g = 0; g < 3; g++) begin
      bad = 0;
      for (int a = 0; a < 1024; a++) if (mem[g][a] !== exp_mem[a]) bad++;
      chk($sformatf("mem_bad_bytes[%0d]", g), 64'(bad), 64'd0);
      lw     = lanes_of(g);
      beats  = (n + lw - 1) / lw;
      pl     = (lw < 8) ? lw : 8;
      pbeats = (ind && n != 0) ? (8 + pl - 1) / pl : 0;
      chk($sformatf("rd_beats[%0d]", g), 64'(rd_beats[g]), 64'(beats + pbeats));
      chk($sformatf("wr_beats[%0d]", g), 64'(wr_beats[g]), 64'(beats));
      chk($sformatf("wr_bytes[%0d]", g), 64'(wr_bytes[g]), 64'(n));
      chk($sformatf("early_drop[%0d]", g), 64'(viol[g]), 64'd0);
      if (n > 0) begin
        chk($sformatf("first_pat[%0d]", g), 64'(first_pat[g]),
            64'(lane_mask((n < lw) ? n : lw)));
        chk($sformatf("last_pat[%0d]", g), 64'(last_pat[g]),
            64'(lane_mask(n - (beats - 1) * lw)));
      end
    end
  endtask

  task automatic reset_mid();
    int cyc;
    rand_img();
    skew = 1'b1;
    fill();
    en          = 1'b1;
    indirect    = 1'b0;
    src_addr    = 64'h20;
    len         = 32'd40;
    write_point = 64'h3F0;
    cyc = 0;
    while (!(d_en[0] != '0 && !d_rdwr[0]) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_rd_wait", 64'(cyc < 200), 64'd1);
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("rst_dram_en[%0d]", g), 64'(d_en[g]), 64'd0);
    chk("rst_ready", 64'(ready_v), 64'h7);
    chk("rst_done", 64'(done_v), 64'h0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          n;
    logic [63:0] src, wp, p;
    bit          ind;

    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready_v), 64'h7);
    chk("reset_done", 64'(done_v), 64'h0);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_dram_en[%0d]", g), 64'(d_en[g]), 64'd0);
      chk($sformatf("reset_nwp[%0d]", g), nwp_v[g], 64'd0);
      chk($sformatf("reset_addr0[%0d]", g), d_addr[g][0], 64'd0);
      chk($sformatf("reset_wdata0[%0d]", g), 64'(d_wdata[g][0]), 64'd0);
    end
    chk("reset_rdwr", 64'(d_rdwr), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Short direct copy.
    rand_img();
    for (int i = 0; i < 5; i++) img[16 + i] = 8'(i + 1);
    run_xfer(1'b0, 64'h10, 5, 64'h300, 1'b0);
    chk("s1_first_byte", 64'(mem[0][10'h2FC]), 64'h01);
    chk("s1_last_byte", 64'(mem[0][10'h300]), 64'h05);
    chk("s1_pattern", 64'(first_pat[0]), 64'h1F);

    // Multi-burst direct copy.
    rand_img();
    run_xfer(1'b0, 64'h40, 19, 64'h300, 1'b0);
    chk("s2_last_pat", 64'(last_pat[0]), 64'h07);

    // Indirect copy through an LE pointer.
    rand_img();
    for (int k = 0; k < 8; k++) img[8 + k] = (k == 0) ? 8'h17 : 8'h00;
    for (int k = 0; k < 8; k++) img[8'h17 + k] = 8'h00;
    img[10'h1F] = 8'hDE;
    img[10'h20] = 8'hAD;
    img[10'h21] = 8'hBE;
    img[10'h22] = 8'hEF;
    run_xfer(1'b1, 64'h8, 12, 64'h300, 1'b0);
    chk("s3_byte_de", 64'(mem[1][10'h2FD]), 64'hDE);
    chk("s3_byte_ef", 64'(mem[2][10'h300]), 64'hEF);

    // Zero length, both modes.
    rand_img();
    run_xfer(1'b0, 64'h30, 0, 64'h280, 1'b0);
    run_xfer(1'b1, 64'h30, 0, 64'h2A0, 1'b0);

    // Skewed completions plus spurious valids on idle lanes.
    rand_img();
    run_xfer(1'b0, 64'h40, 19, 64'h300, 1'b1);

    // Reset mid-read, then a clean repeat of the short copy.
    reset_mid();
    rand_img();
    for (int i = 0; i < 5; i++) img[16 + i] = 8'(i + 1);
    run_xfer(1'b0, 64'h10, 5, 64'h300, 1'b0);

    // Random transfers.
    for (int t = 0; t < 10; t++) begin
      rand_img();
      ind = 1'($urandom);
      n   = $urandom_range(1, 60);
      wp  = 64'($urandom_range(32'h240, 32'h3FF));
      src = 64'($urandom_range(0, 32'hF0));
      if (ind) begin
        p = 64'($urandom_range(32'h100, 32'h160));
        for (int k = 0; k < 8; k++) img[10'(src + 64'(k))] = p[k*8 +: 8];
      end
      run_xfer(ind, src, n, wp, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
